icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's `icache_req`/`icache_addr` requests and returns `icache_data`/`icache_valid`. Hits are answered combinationally in the request cycle. A miss latches the address, refills the whole line from the instruction memory port one word per beat, then returns the missed word in a single response cycle, whether or not the request is still asserted. A `flush` input invalidates the whole cache, for FENCE.I-style invalidation.

---
 rtl/icache_if.sv | 24 ++
 rtl/icache.sv | 135 +++++++++++++
 tb/tb_icache.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and refill-side signal bundle for the instruction cache.
// The slave modport is the cache itself; master is whoever surrounds it
// (fetch stage plus instruction memory).
interface icache_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;

    modport master (
        output icache_req, icache_addr, flush, mem_data, mem_valid,
        input  icache_data, icache_valid, mem_req, mem_addr
    );

    modport slave (
        input  icache_req, icache_addr, flush, mem_data, mem_valid,
        output icache_data, icache_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with combinational hits,
// in-order whole-line refill and a one-cycle response after each miss.
// A flush invalidates every line; a flush landing mid-refill lets the
// refill finish and answer, but leaves the refilled line invalid.
module icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int WOFF = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 32 - IDX - WOFF - 2;
    localparam logic [WOFF-1:0] LAST_BEAT = WOFF'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]           r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAGW-1:0]      r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
    logic [31:2]          r_missAddr;
    logic [WOFF-1:0]      r_cnt;
    logic                 r_kill;

    logic [WOFF-1:0] w_reqWoff;
    logic [IDX-1:0]  w_reqIdx;
    logic [TAGW-1:0] w_reqTag;
    logic [WOFF-1:0] w_missWoff;
    logic [IDX-1:0]  w_missIdx;
    logic [TAGW-1:0] w_missTag;
    logic            w_hit;
    logic            w_beat;
    logic            w_lastBeat;

    assign w_reqWoff  = bus.icache_addr[WOFF+1:2];
    assign w_reqIdx   = bus.icache_addr[IDX+WOFF+1:WOFF+2];
    assign w_reqTag   = bus.icache_addr[31:IDX+WOFF+2];
    assign w_missWoff = r_missAddr[WOFF+1:2];
    assign w_missIdx  = r_missAddr[IDX+WOFF+1:WOFF+2];
    assign w_missTag  = r_missAddr[31:IDX+WOFF+2];

    assign w_hit      = bus.icache_req && r_valid[w_reqIdx] && (r_tag[w_reqIdx] == w_reqTag);
    assign w_beat     = (r_state == S_REFILL) && bus.mem_valid;
    assign w_lastBeat = w_beat && (r_cnt == LAST_BEAT);

    // Output decode: hit data in IDLE, beat address in REFILL, missed word in RESP.
    always_comb begin
        bus.icache_valid = 1'b0;
        bus.icache_data  = 32'h0;
        bus.mem_req      = 1'b0;
        bus.mem_addr     = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    bus.icache_valid = 1'b1;
                    bus.icache_data  = r_data[{w_reqIdx, w_reqWoff}];
                end
            end
            S_REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {w_missTag, w_missIdx, r_cnt, 2'b00};
            end
            S_RESP: begin
                bus.icache_valid = 1'b1;
                bus.icache_data  = r_data[{w_missIdx, w_missWoff}];
            end
            default: begin
            end
        endcase
    end

    // Control state, beat counter, kill flag and valid bits; a flush always wins over a line becoming valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_cnt      <= '0;
            r_kill     <= 1'b0;
            r_missAddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (bus.flush) begin
                        r_valid <= '0;
                    end
                    if (bus.icache_req && !w_hit) begin
                        r_missAddr <= bus.icache_addr[31:2];
                        r_cnt      <= '0;
                        r_state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                        r_kill  <= 1'b1;
                    end else if (w_lastBeat && !r_kill) begin
                        r_valid[w_missIdx] <= 1'b1;
                    end
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_lastBeat) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage are plain registers with no reset; only the valid bits say what is usable.
    always_ff @(posedge clk) begin
        if (!rst && w_beat) begin
            r_data[{w_missIdx, r_cnt}] <= bus.mem_data;
            if (w_lastBeat) begin
                r_tag[w_missIdx] <= w_missTag;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a table of per-cycle vectors for the main
// miss/hit/conflict/flush flow, then hand-written sequences for memory
// stalls, flush during refill and reset during refill.
// The memory model answers with data equal to the requested address.
module tb_icache;
    logic clk;
    logic rst;
    int   vecCount;
    int   missCount;

    icache_if bus ();

    icache #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory returns its own word address as the instruction.
    assign bus.mem_data = bus.mem_addr;

    // Free-running clock, active edge at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        flush;
        logic        memValid;
        logic        expValid;
        logic [31:0] expData;
        logic        expMemReq;
        logic [31:0] expMemAddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic flush,
                                input logic memValid, input logic expValid, input logic [31:0] expData,
                                input logic expMemReq, input logic [31:0] expMemAddr);
        vec_t v;
        v.req        = req;
        v.addr       = addr;
        v.flush      = flush;
        v.memValid   = memValid;
        v.expValid   = expValid;
        v.expData    = expData;
        v.expMemReq  = expMemReq;
        v.expMemAddr = expMemAddr;
        return v;
    endfunction

    // Drive one cycle's inputs just after the falling edge and let them settle.
    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic flush,
                                 input logic memValid, input logic rstVal);
        @(negedge clk);
        rst             = rstVal;
        bus.icache_req  = req;
        bus.icache_addr = addr;
        bus.flush       = flush;
        bus.mem_valid   = memValid;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expData,
                               input logic expMemReq, input logic [31:0] expMemAddr);
        vecCount++;
        if (bus.icache_valid !== expValid || bus.icache_data !== expData ||
            bus.mem_req !== expMemReq || bus.mem_addr !== expMemAddr) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%b data=%h mem_req=%b mem_addr=%h, want valid=%b data=%h mem_req=%b mem_addr=%h",
                     name, bus.icache_valid, bus.icache_data, bus.mem_req, bus.mem_addr,
                     expValid, expData, expMemReq, expMemAddr);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        rst             = 1'b1;
        bus.icache_req  = 1'b0;
        bus.icache_addr = 32'h0;
        bus.flush       = 1'b0;
        bus.mem_valid   = 1'b0;

        // Cold miss on 0x104, in-order refill, response at T+5, then hits.
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    1, 32'h100));
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    1, 32'h104));
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    1, 32'h108));
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    1, 32'h10C));
        vecs.push_back(mk(1, 32'h104,  0, 1, 1, 32'h104,  0, 32'h0));
        vecs.push_back(mk(1, 32'h10C,  0, 1, 1, 32'h10C,  0, 32'h0));
        vecs.push_back(mk(0, 32'h10C,  0, 1, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(1, 32'h100,  0, 1, 1, 32'h100,  0, 32'h0));
        // Conflict miss: 0x1100 shares index 0 with 0x100.
        vecs.push_back(mk(1, 32'h1100, 0, 1, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h1100));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h1104));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h1108));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h110C));
        vecs.push_back(mk(0, 32'h0,    0, 1, 1, 32'h1100, 0, 32'h0));
        vecs.push_back(mk(1, 32'h1108, 0, 1, 1, 32'h1108, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100,  0, 1, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h100));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h104));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h108));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h10C));
        // A request presented in the RESP cycle is ignored.
        vecs.push_back(mk(1, 32'h2000, 0, 1, 1, 32'h100,  0, 32'h0));
        vecs.push_back(mk(1, 32'h104,  0, 1, 1, 32'h104,  0, 32'h0));
        // Flush in IDLE: this cycle's hit stands, the next request misses.
        vecs.push_back(mk(1, 32'h104,  1, 1, 1, 32'h104,  0, 32'h0));
        vecs.push_back(mk(1, 32'h104,  0, 1, 0, 32'h0,    0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h100));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h104));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h108));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    1, 32'h10C));
        vecs.push_back(mk(0, 32'h0,    0, 1, 1, 32'h104,  0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,    0, 32'h0));

        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("reset_idle", 0, 32'h0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].flush, vecs[i].memValid, 0);
            checkOutput($sformatf("table_%0d", i), vecs[i].expValid, vecs[i].expData,
                        vecs[i].expMemReq, vecs[i].expMemAddr);
        end

        // Memory stall: beats only every 3rd cycle, requester drops req during refill.
        applyStimulus(1, 32'h204, 0, 0, 0);
        checkOutput("stall_miss", 0, 32'h0, 0, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 32'h0, 0, (k % 3 == 0), 0);
            checkOutput($sformatf("stall_beat_%0d", k), 0, 32'h0, 1, 32'h200 + 32'(4 * ((k - 1) / 3)));
        end
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("stall_resp", 1, 32'h204, 0, 32'h0);
        applyStimulus(1, 32'h208, 0, 0, 0);
        checkOutput("stall_hit", 1, 32'h208, 0, 32'h0);

        // Flush during the 2nd beat: response still arrives, line stays invalid.
        applyStimulus(1, 32'h300, 0, 1, 0);
        checkOutput("kill_miss", 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("kill_beat0", 0, 32'h0, 1, 32'h300);
        applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("kill_beat1", 0, 32'h0, 1, 32'h304);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("kill_beat3", 0, 32'h0, 1, 32'h30C);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("kill_resp", 1, 32'h300, 0, 32'h0);
        applyStimulus(1, 32'h300, 0, 1, 0);
        checkOutput("kill_remiss", 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 32'h0, 0, 1, 0);
        end
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("kill_resp2", 1, 32'h300, 0, 32'h0);
        applyStimulus(1, 32'h308, 0, 1, 0);
        checkOutput("kill_cleared_hit", 1, 32'h308, 0, 32'h0);

        // Reset during beat 2 abandons the refill; the line must be fetched again from beat 0.
        applyStimulus(1, 32'h404, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 1);
        checkOutput("rst_beat2", 0, 32'h0, 1, 32'h408);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("rst_after", 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 32'h404, 0, 1, 0);
        checkOutput("rst_remiss", 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("rst_beat0", 0, 32'h0, 1, 32'h400);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("rst_resp", 1, 32'h404, 0, 32'h0);
        applyStimulus(1, 32'h300, 0, 1, 0);
        checkOutput("rst_old_line_gone", 0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
